// File: rtl/gen_fifo_serializer_pkg.sv
// Shared definitions for the wide-FIFO serializer: lane-index width derivation,
// lane-index type and FSM state encoding.
package gen_fifo_serializer_pkg;

   localparam int unsigned DefDw = 64;
   localparam int unsigned DefRp = 4;

   // Lane index width for an RP-lane bundle; never narrower than one bit.
   function automatic int unsigned calc_lw(input int unsigned rp);
      return (rp <= 2) ? 1 : $clog2(rp);
   endfunction

   localparam int unsigned DefLw = calc_lw(DefRp);

   // Lane numbering shared by the wide FIFO producer and its consumers.
   typedef logic [DefLw-1:0] lane_idx_t;

   typedef enum logic {
      StIdle = 1'b0,
      StHold = 1'b1
   } state_e;

endpackage

// File: rtl/gen_dffr.sv
// Standard D flip-flop with enable and synchronous active-high reset.
module gen_dffr #(
   parameter int unsigned   W      = 1,
   parameter logic [W-1:0]  RstVal = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Reset wins over enable; hold when not enabled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= RstVal;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/gen_lowbit_enc.sv
// Lowest-set-bit encoder: index and one-hot of the lowest set bit, plus a flag
// that is high when exactly one bit of the input is set.
module gen_lowbit_enc
   import gen_fifo_serializer_pkg::*;
#(
   parameter int unsigned RP = DefRp,
   parameter int unsigned LW = calc_lw(RP)
) (
   input  logic [RP-1:0] i_vec,
   output logic [LW-1:0] o_idx,
   output logic [RP-1:0] o_onehot,
   output logic          o_onehot_only
);

   logic [LW-1:0] w_idx;

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      w_idx = '0;
      for (int i = int'(RP) - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            w_idx = LW'(i);
         end
      end
   end

   assign o_idx         = w_idx;
   // Two's-complement trick isolates the lowest set bit.
   assign o_onehot      = i_vec & (~i_vec + RP'(1));
   assign o_onehot_only = (i_vec != '0) && ((i_vec & (i_vec - RP'(1))) == '0);

endmodule

// File: rtl/gen_fifo_serializer.sv
// Serializes RP-lane bundles from a show-ahead wide FIFO into a single-item
// valid/ready stream, valid lanes in ascending order, one item per cycle.
module gen_fifo_serializer
   import gen_fifo_serializer_pkg::*;
#(
   parameter int unsigned DW = DefDw,
   parameter int unsigned RP = DefRp,
   parameter int unsigned LW = calc_lw(RP)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             fifo_empty,
   input  logic [DW*RP-1:0] data_r,
   input  logic [RP-1:0]    lane_vld,
   output logic             fifo_pop,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [DW-1:0]    deq_data,
   output logic [LW-1:0]    deq_lane,
   output logic             deq_last,
   input  logic             flush
);

   state_e           w_state;
   state_e           w_state_d;
   logic             w_state_q;
   logic [RP-1:0]    r_rem;
   logic [RP-1:0]    w_rem_d;
   logic [DW*RP-1:0] r_buf;

   logic [LW-1:0]    w_idx;
   logic [RP-1:0]    w_onehot;
   logic             w_only;
   logic             w_hold;
   logic             w_accept;
   logic             w_pop;
   logic [DW-1:0]    w_deq_data;

   // Current lane and last-lane detection from the remaining mask.
   gen_lowbit_enc #(
      .RP (RP),
      .LW (LW)
   ) u_enc (
      .i_vec         (r_rem),
      .o_idx         (w_idx),
      .o_onehot      (w_onehot),
      .o_onehot_only (w_only)
   );

   // State register.
   gen_dffr #(
      .W      (1),
      .RstVal (1'b0)
   ) u_state_reg (
      .i_clk (CLK),
      .i_rst (RST),
      .i_en  (1'b1),
      .i_d   (w_state_d),
      .o_q   (w_state_q)
   );

   assign w_state = state_e'(w_state_q);

   // Remaining-lane mask register.
   gen_dffr #(
      .W      (RP),
      .RstVal ('0)
   ) u_rem_reg (
      .i_clk (CLK),
      .i_rst (RST),
      .i_en  (1'b1),
      .i_d   (w_rem_d),
      .o_q   (r_rem)
   );

   // Bundle buffer: loaded only on pop, so deq_data never sees data_r directly.
   gen_dffr #(
      .W      (DW * RP),
      .RstVal ('0)
   ) u_buf_reg (
      .i_clk (CLK),
      .i_rst (RST),
      .i_en  (w_pop),
      .i_d   (data_r),
      .o_q   (r_buf)
   );

   assign w_hold   = (w_state == StHold);
   assign w_accept = w_hold & deq_ready;
   // Pop when idle, or in the cycle the last lane of the held bundle is taken.
   assign w_pop    = ~fifo_empty & ~flush & ~RST & (~w_hold | (w_accept & w_only));

   // Next-state logic for the FSM and the remaining mask.
   always_comb begin
      w_state_d = w_state;
      w_rem_d   = r_rem;
      if (flush) begin
         w_state_d = StIdle;
         w_rem_d   = '0;
      end else if (w_pop) begin
         // An all-zero bundle is consumed and dropped.
         w_state_d = (lane_vld != '0) ? StHold : StIdle;
         w_rem_d   = lane_vld;
      end else if (w_accept) begin
         w_state_d = w_only ? StIdle : StHold;
         w_rem_d   = r_rem & ~w_onehot;
      end
   end

   // AND-OR mux of the held bundle by the current lane's one-hot.
   always_comb begin
      w_deq_data = '0;
      for (int i = 0; i < int'(RP); i++) begin
         if (w_onehot[i]) begin
            w_deq_data = w_deq_data | r_buf[DW*i +: DW];
         end
      end
   end

   // Output logic.
   always_comb begin
      fifo_pop  = w_pop;
      deq_valid = w_hold;
      deq_data  = w_deq_data;
      deq_lane  = w_idx;
      deq_last  = w_only;
   end

endmodule

// File: tb/tb_gen_fifo_serializer.sv
// Directed bench for gen_fifo_serializer: a queue stands in for the wide FIFO,
// outputs are snapshotted on the falling edge and checked against hand values.
module tb_gen_fifo_serializer;

   localparam int unsigned DW = 64;
   localparam int unsigned RP = 4;

   typedef struct packed {
      logic [RP-1:0]    m;
      logic [DW*RP-1:0] d;
   } bndl_t;

   logic             CLK = 1'b0;
   logic             RST;
   logic             fifo_empty;
   logic [DW*RP-1:0] data_r;
   logic [RP-1:0]    lane_vld;
   logic             fifo_pop;
   logic             deq_valid;
   logic             deq_ready;
   logic [DW-1:0]    deq_data;
   logic [1:0]       deq_lane;
   logic             deq_last;
   logic             flush;

   bndl_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   logic        s_pop, s_empty, s_valid, s_last;
   logic [1:0]  s_lane;
   logic [63:0] s_data;

   always #5 CLK = ~CLK;

   gen_fifo_serializer #(
      .DW (DW),
      .RP (RP)
   ) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .fifo_empty (fifo_empty),
      .data_r     (data_r),
      .lane_vld   (lane_vld),
      .fifo_pop   (fifo_pop),
      .deq_valid  (deq_valid),
      .deq_ready  (deq_ready),
      .deq_data   (deq_data),
      .deq_lane   (deq_lane),
      .deq_last   (deq_last),
      .flush      (flush)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_head();
      if (q.size() == 0) begin
         fifo_empty = 1'b1;
         data_r     = {(DW*RP){1'b1}};
         lane_vld   = '0;
      end else begin
         fifo_empty = 1'b0;
         data_r     = q[0].d;
         lane_vld   = q[0].m;
      end
   endtask

   // Lane i of the pushed bundle carries base + i.
   task automatic push(input logic [RP-1:0] mask, input logic [63:0] base);
      bndl_t b;
      b.m = mask;
      for (int i = 0; i < int'(RP); i++) begin
         b.d[DW*i +: DW] = base + 64'(i);
      end
      q.push_back(b);
      drive_head();
   endtask

   // One clock cycle: snapshot outputs mid-cycle, then advance the FIFO model.
   task automatic cyc();
      @(negedge CLK);
      s_pop   = fifo_pop;
      s_empty = fifo_empty;
      s_valid = deq_valid;
      s_last  = deq_last;
      s_lane  = deq_lane;
      s_data  = deq_data;
      chk("pop_while_empty", {63'd0, s_pop & s_empty}, 64'd0);
      @(posedge CLK);
      #1;
      if (s_pop && q.size() > 0) begin
         void'(q.pop_front());
      end
      drive_head();
   endtask

   task automatic exp_item(input string tag, input logic [63:0] data, input logic [1:0] lane,
                           input logic last, input logic pop);
      chk({tag, "_valid"}, {63'd0, s_valid}, 64'd1);
      chk({tag, "_data"}, s_data, data);
      chk({tag, "_lane"}, {62'd0, s_lane}, {62'd0, lane});
      chk({tag, "_last"}, {63'd0, s_last}, {63'd0, last});
      chk({tag, "_pop"}, {63'd0, s_pop}, {63'd0, pop});
   endtask

   task automatic exp_idle(input string tag, input logic pop);
      chk({tag, "_valid"}, {63'd0, s_valid}, 64'd0);
      chk({tag, "_pop"}, {63'd0, s_pop}, {63'd0, pop});
   endtask

   initial begin
      RST       = 1'b1;
      flush     = 1'b0;
      deq_ready = 1'b1;
      drive_head();
      @(posedge CLK);
      #1;

      // Reset: outputs at reset values, no pop despite a non-empty head.
      push(4'b1111, 64'hA0);
      cyc();
      exp_idle("rst", 1'b0);
      chk("rst_last", {63'd0, s_last}, 64'd0);
      chk("rst_lane", {62'd0, s_lane}, 64'd0);
      chk("rst_data", s_data, 64'd0);

      // Full bundle: pop in N, A0..A3 in N+1..N+4.
      RST = 1'b0;
      cyc();
      exp_idle("full_n", 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         exp_item("full", 64'hA0 + 64'(i), 2'(i), (i == 3), 1'b0);
      end
      cyc();
      exp_idle("full_after", 1'b0);

      // Sparse 1010 then two full bundles back to back.
      push(4'b1010, 64'hB0);
      push(4'b1111, 64'hE0);
      push(4'b1111, 64'hF0);
      cyc();
      exp_idle("sparse_n", 1'b1);
      cyc();
      exp_item("sparse_b1", 64'hB1, 2'd1, 1'b0, 1'b0);
      cyc();
      exp_item("sparse_b3", 64'hB3, 2'd3, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         cyc();
         exp_item("b2b", (i < 4) ? 64'hE0 + 64'(i) : 64'hF0 + 64'(i - 4), 2'(i % 4),
                  (i % 4 == 3), (i == 3));
      end
      cyc();
      exp_idle("b2b_after", 1'b0);

      // Backpressure mid-bundle.
      push(4'b1111, 64'h10);
      cyc();
      exp_idle("bp_n", 1'b1);
      cyc();
      exp_item("bp_0", 64'h10, 2'd0, 1'b0, 1'b0);
      deq_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         exp_item("bp_stall", 64'h11, 2'd1, 1'b0, 1'b0);
      end
      deq_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         cyc();
         exp_item("bp_resume", 64'h10 + 64'(i), 2'(i), (i == 3), 1'b0);
      end
      cyc();
      exp_idle("bp_after", 1'b0);

      // All-zero bundle dropped, then single-lane bundle.
      push(4'b0000, 64'hC8);
      push(4'b0001, 64'hC0);
      cyc();
      exp_idle("zero_pop", 1'b1);
      cyc();
      exp_idle("zero_next", 1'b1);
      cyc();
      exp_item("zero_c0", 64'hC0, 2'd0, 1'b1, 1'b0);
      cyc();
      exp_idle("zero_after", 1'b0);

      // Flush after two of four lanes.
      push(4'b1111, 64'h20);
      push(4'b1100, 64'h30);
      cyc();
      exp_idle("fl_n", 1'b1);
      cyc();
      exp_item("fl_0", 64'h20, 2'd0, 1'b0, 1'b0);
      cyc();
      exp_item("fl_1", 64'h21, 2'd1, 1'b0, 1'b0);
      flush = 1'b1;
      cyc();
      exp_item("fl_cyc", 64'h22, 2'd2, 1'b0, 1'b0);
      flush = 1'b0;
      cyc();
      exp_idle("fl_next", 1'b1);
      cyc();
      exp_item("fl_32", 64'h32, 2'd2, 1'b0, 1'b0);
      cyc();
      exp_item("fl_33", 64'h33, 2'd3, 1'b1, 1'b0);

      // Flush while idle suppresses the pop of a waiting head.
      push(4'b1111, 64'h60);
      flush = 1'b1;
      cyc();
      exp_idle("fl_idle", 1'b0);
      flush = 1'b0;
      cyc();
      exp_idle("fl_idle_next", 1'b1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         exp_item("fl_idle_drain", 64'h60 + 64'(i), 2'(i), (i == 3), 1'b0);
      end

      // Reset after two of four lanes.
      push(4'b1111, 64'h40);
      push(4'b0001, 64'h50);
      cyc();
      exp_idle("rs_n", 1'b1);
      cyc();
      exp_item("rs_0", 64'h40, 2'd0, 1'b0, 1'b0);
      cyc();
      exp_item("rs_1", 64'h41, 2'd1, 1'b0, 1'b0);
      RST = 1'b1;
      cyc();
      chk("rs_cyc_pop", {63'd0, s_pop}, 64'd0);
      RST = 1'b0;
      cyc();
      exp_idle("rs_next", 1'b1);
      cyc();
      exp_item("rs_50", 64'h50, 2'd0, 1'b1, 1'b0);
      cyc();
      exp_idle("rs_after", 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
